// File: rtl/execute_adder_result_stage_pkg.sv
// Shared core definitions: flag bit positions, flag width and the
// buffered-entry field layout used by adder, result stage and writeback.
package execute_adder_result_stage_pkg;

  localparam int FLAG_W  = 5;
  localparam int FLAG_ZF = 4;
  localparam int FLAG_PF = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_SF = 1;
  localparam int FLAG_CF = 0;

  // Entry layout, MSB first: {data, flags, flags_wb, dest, dest_wb}
  function automatic int entry_width(input int n, input int dest_w);
    return n + FLAG_W + 1 + dest_w + 1;
  endfunction

endpackage

// File: rtl/execute_result_fifo2.sv
// Generic 2-entry in-order valid/busy buffer with flush.
// Ports: in_* upstream side, out_* downstream side, flush clears all.
module execute_result_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_busy,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_busy,
  output logic [W-1:0] out_data
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic [1:0]        count_q, count_d;
  logic              push, pop;

  // Busy comes from registered count only, never from out_busy.
  assign in_busy   = (count_q == 2'd2);
  assign out_valid = (count_q != 2'd0) & ~flush;
  assign out_data  = mem_q[rptr_q];

  assign push = in_valid & ~in_busy & ~flush;
  assign pop  = out_valid & ~out_busy;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = in_data;
        wptr_d        = ~wptr_q;
      end
      if (pop) begin
        rptr_d = ~rptr_q;
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/execute_adder_result_stage.sv
// Adder result stage: buffers adder results for writeback and commits
// flags to the architectural flag register when an entry is handed off.
module execute_adder_result_stage
  import execute_adder_result_stage_pkg::*;
#(
  parameter int P_N      = 32,
  parameter int P_DEST_W = 5
) (
  input  logic                iCLOCK,
  input  logic                iRESET_SYNC,
  input  logic                iEVENT_FLUSH,
  input  logic                iPREV_VALID,
  output logic                oPREV_BUSY,
  input  logic [P_N-1:0]      iPREV_DATA,
  input  logic [FLAG_W-1:0]   iPREV_FLAGS,
  input  logic                iPREV_FLAGS_WB,
  input  logic [P_DEST_W-1:0] iPREV_DEST,
  input  logic                iPREV_DEST_WB,
  output logic                oNEXT_VALID,
  input  logic                iNEXT_BUSY,
  output logic [P_N-1:0]      oNEXT_DATA,
  output logic [FLAG_W-1:0]   oNEXT_FLAGS,
  output logic [P_DEST_W-1:0] oNEXT_DEST,
  output logic                oNEXT_DEST_WB,
  output logic [FLAG_W-1:0]   oFLAGS
);

  localparam int W = entry_width(P_N, P_DEST_W);

  logic [W-1:0]      in_entry, head_entry;
  logic              head_flags_wb;
  logic              pop;
  logic [FLAG_W-1:0] flags_q, flags_d;

  assign in_entry = {iPREV_DATA, iPREV_FLAGS, iPREV_FLAGS_WB,
                     iPREV_DEST, iPREV_DEST_WB};

  execute_result_fifo2 #(
    .W (W)
  ) u_fifo (
    .clk       (iCLOCK),
    .rst       (iRESET_SYNC),
    .flush     (iEVENT_FLUSH),
    .in_valid  (iPREV_VALID),
    .in_busy   (oPREV_BUSY),
    .in_data   (in_entry),
    .out_valid (oNEXT_VALID),
    .out_busy  (iNEXT_BUSY),
    .out_data  (head_entry)
  );

  assign {oNEXT_DATA, oNEXT_FLAGS, head_flags_wb,
          oNEXT_DEST, oNEXT_DEST_WB} = head_entry;

  // oNEXT_VALID is already gated by flush, so no commit in a flush cycle.
  assign pop = oNEXT_VALID & ~iNEXT_BUSY;

  always_comb begin
    flags_d = flags_q;
    if (pop && head_flags_wb) begin
      flags_d = oNEXT_FLAGS;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign oFLAGS = flags_q;

endmodule
